// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: default geometry,
// operating-mode encoding, per-stage control struct and the full-adder cell.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Control part of a stage register; data widths vary per stage so they
    // live beside it in the pipeline itself.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    function automatic logic stage0_carry(input mode_e mode, input logic c_in);
        logic carry;
        case (mode)
            MODE_ADD: carry = c_in;
            MODE_SUB: carry = 1'b1;
            default:  carry = c_in;
        endcase
        return carry;
    endfunction

    // Returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic [1:0] r;
        r[0] = x ^ y ^ ci;
        r[1] = (x & y) | (ci & (x ^ y));
        return r;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry slice built from full-adder cells; one per
// pipeline stage.
module adder_slice
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic carry_s;

    // ripple the carry through the cells, LSB first
    always_comb begin
        carry_s = c_in;
        sum     = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            {carry_s, sum[i]} = full_add(a[i], b[i], carry_s);
        end
        c_out = carry_s;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage.
// Define PIPE_ADDER_FLAGS_EN to build the registered overflow/zero flags.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             adv_s;
    logic [WIDTH-1:0] b_cap_s;
    logic             carry0_s;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;

    // global advance: the whole pipe moves unless a result is waiting unread
    always_comb begin
        adv_s = !out_valid_q || out_ready;
    end

    // operand conditioning at capture
    always_comb begin
        carry0_s = stage0_carry(mode_e'(sub), c_in);
        if (mode_e'(sub) == MODE_SUB) begin
            b_cap_s = ~b;
        end else begin
            b_cap_s = b;
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * CHUNK;
        localparam int DONE = LO + CHUNK;
        localparam int REM  = WIDTH - DONE;

        logic [WIDTH-LO-1:0] a_in_s;
        logic [WIDTH-LO-1:0] b_in_s;
        stage_ctrl_t         ctrl_in_s;
        logic [CHUNK-1:0]    slice_sum_s;
        logic                slice_cout_s;
        logic [DONE-1:0]     done_sum_s;

        adder_slice #(.WIDTH(CHUNK)) u_slice (
            .a     (a_in_s[CHUNK-1:0]),
            .b     (b_in_s[CHUNK-1:0]),
            .c_in  (ctrl_in_s.carry),
            .sum   (slice_sum_s),
            .c_out (slice_cout_s)
        );

        if (k == 0) begin : g_first
            assign a_in_s     = a;
            assign b_in_s     = b_cap_s;
            assign ctrl_in_s  = '{valid: in_valid, carry: carry0_s};
            assign done_sum_s = slice_sum_s;
        end else begin : g_next
            assign a_in_s     = g_stage[k-1].g_mid.a_q;
            assign b_in_s     = g_stage[k-1].g_mid.b_q;
            assign ctrl_in_s  = g_stage[k-1].g_mid.ctrl_q;
            assign done_sum_s = {slice_sum_s, g_stage[k-1].g_mid.sum_q};
        end

        if (k < STAGES - 1) begin : g_mid
            // Only the not-yet-added upper operand bits travel forward.
            stage_ctrl_t     ctrl_q, ctrl_d;
            logic [DONE-1:0] sum_q, sum_d;
            logic [REM-1:0]  a_q, a_d;
            logic [REM-1:0]  b_q, b_d;

            // next state of an intermediate stage register
            always_comb begin
                if (adv_s) begin
                    ctrl_d.valid = ctrl_in_s.valid;
                    ctrl_d.carry = slice_cout_s;
                    sum_d        = done_sum_s;
                    a_d          = a_in_s[WIDTH-LO-1:CHUNK];
                    b_d          = b_in_s[WIDTH-LO-1:CHUNK];
                end else begin
                    ctrl_d = ctrl_q;
                    sum_d  = sum_q;
                    a_d    = a_q;
                    b_d    = b_q;
                end
            end

            // intermediate stage register
            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    ctrl_q <= stage_ctrl_t'(2'b00);
                    sum_q  <= {DONE{1'b0}};
                    a_q    <= {REM{1'b0}};
                    b_q    <= {REM{1'b0}};
                end else begin
                    ctrl_q <= ctrl_d;
                    sum_q  <= sum_d;
                    a_q    <= a_d;
                    b_q    <= b_d;
                end
            end
        end else begin : g_last
            // next state of the result register
            always_comb begin
                if (adv_s) begin
                    out_valid_d = ctrl_in_s.valid;
                    sum_d       = done_sum_s;
                    c_out_d     = slice_cout_s;
                end else begin
                    out_valid_d = out_valid_q;
                    sum_d       = sum_q;
                    c_out_d     = c_out_q;
                end
            end

            // result register
            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= {WIDTH{1'b0}};
                    c_out_q     <= 1'b0;
                end else begin
                    out_valid_q <= out_valid_d;
                    sum_q       <= sum_d;
                    c_out_q     <= c_out_d;
                end
            end

`ifdef PIPE_ADDER_FLAGS_EN
            logic overflow_q, overflow_d;
            logic zero_q, zero_d;

            // flags use the MSB slice inputs, so b is already inverted for subtract
            always_comb begin
                if (adv_s) begin
                    overflow_d = (a_in_s[CHUNK-1] == b_in_s[CHUNK-1]) &&
                                 (slice_sum_s[CHUNK-1] != a_in_s[CHUNK-1]);
                    zero_d     = (done_sum_s == {WIDTH{1'b0}});
                end else begin
                    overflow_d = overflow_q;
                    zero_d     = zero_q;
                end
            end

            // flag registers, aligned with sum
            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    overflow_q <= 1'b0;
                    zero_q     <= 1'b0;
                end else begin
                    overflow_q <= overflow_d;
                    zero_q     <= zero_d;
                end
            end

            assign overflow = overflow_q;
            assign zero     = zero_q;
`else
            assign overflow = 1'b0;
            assign zero     = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised self-checking bench for pipe_adder (WIDTH=32, STAGES=4) against
// an arithmetic reference model with a cycle-accurate result queue.
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef PIPE_ADDER_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    typedef logic [WIDTH-1:0] word_t;

    typedef struct {
        word_t sum;
        logic  c_out;
        logic  ovf;
        logic  zero;
        int    issue_cyc;
        int    issue_stall;
    } exp_t;

    logic  clock = 1'b0;
    logic  clear;
    logic  in_valid;
    logic  in_ready;
    word_t a;
    word_t b;
    logic  c_in;
    logic  sub;
    logic  out_valid;
    logic  out_ready;
    word_t sum;
    logic  c_out;
    logic  overflow;
    logic  zero;

    exp_t exp_q[$];
    int   cyc_cnt   = 0;
    int   stall_cnt = 0;
    int   n_vec     = 0;
    int   n_fail    = 0;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    // Reference: exact integer add/subtract, wrapped to WIDTH bits.
    function automatic exp_t model(input word_t x, input word_t y, input logic cin, input logic s);
        exp_t                    e;
        logic [WIDTH:0]          full;
        logic signed [WIDTH+1:0] exact;
        logic signed [WIDTH+1:0] sx;
        logic signed [WIDTH+1:0] sy;
        sx = $signed({{2{x[WIDTH-1]}}, x});
        sy = $signed({{2{y[WIDTH-1]}}, y});
        if (s) begin
            full    = {1'b0, x} - {1'b0, y};
            e.c_out = (x >= y);
            exact   = sx - sy;
        end else begin
            full    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
            e.c_out = full[WIDTH];
            exact   = sx + sy + $signed({{(WIDTH+1){1'b0}}, cin});
        end
        e.sum         = full[WIDTH-1:0];
        e.ovf         = FLAGS_ON ? (exact != $signed({{2{e.sum[WIDTH-1]}}, e.sum})) : 1'b0;
        e.zero        = FLAGS_ON ? (e.sum == {WIDTH{1'b0}}) : 1'b0;
        e.issue_cyc   = 0;
        e.issue_stall = 0;
        return e;
    endfunction

    function automatic word_t pick_operand();
        word_t w;
        case ($urandom_range(0, 5))
            0:       w = {WIDTH{1'b0}};
            1:       w = {WIDTH{1'b1}};
            2:       w = {1'b1, {(WIDTH-1){1'b0}}};
            3:       w = {1'b0, {(WIDTH-1){1'b1}}};
            default: w = $urandom();
        endcase
        return w;
    endfunction

    // One cycle, entered and left at a falling edge.
    task automatic step(input logic iv, input word_t xa, input word_t xb,
                        input logic cin, input logic s, input logic ordy);
        logic exp_ov;
        logic adv;
        exp_t e;
        exp_ov = (exp_q.size() > 0) &&
                 (((cyc_cnt - exp_q[0].issue_cyc) - (stall_cnt - exp_q[0].issue_stall)) >= STAGES);
        check_val("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            check_val("sum", sum, exp_q[0].sum);
            check_val("c_out", c_out, exp_q[0].c_out);
            check_val("overflow", overflow, exp_q[0].ovf);
            check_val("zero", zero, exp_q[0].zero);
        end
        out_ready = ordy;
        adv = !exp_ov || ordy;
        if (exp_ov && ordy) void'(exp_q.pop_front());
        if (!adv) stall_cnt++;
        in_valid = iv;
        a        = xa;
        b        = xb;
        c_in     = cin;
        sub      = s;
        if (iv && adv) begin
            e             = model(xa, xb, cin, s);
            e.issue_cyc   = cyc_cnt;
            e.issue_stall = stall_cnt;
            exp_q.push_back(e);
        end
        #1;
        check_val("in_ready", in_ready, adv);
        @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * STAGES + 20 && exp_q.size() > 0; i++) begin
            step(1'b0, {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0, 1'b0, 1'b1);
        end
        check_val("drain_empty", exp_q.size(), 0);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        clear     = 1'b1;
        in_valid  = 1'b0;
        a         = {WIDTH{1'b0}};
        b         = {WIDTH{1'b0}};
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_sum", sum, {WIDTH{1'b0}});
        check_val("rst_c_out", c_out, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_zero", zero, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);
        clear = 1'b0;
        @(negedge clock);

        // directed: back-to-back adds, subtract edges, carry across every slice
        step(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h00FF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        drain();

        // 8 ops with a 3-cycle output stall while results are present
        for (int i = 0; i < 12; i++) begin
            step(i < 8, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), !(i >= 4 && i < 7));
        end
        drain();

        random_phase(400);
        drain();

        // clear with ops in flight and one result stalled at the output
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h0000_1001 + i, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        clear    = 1'b1;
        #1;
        check_val("clr_out_valid", out_valid, 1'b0);
        check_val("clr_sum", sum, {WIDTH{1'b0}});
        check_val("clr_in_ready", in_ready, 1'b1);
        exp_q.delete();
        @(negedge clock);
        clear = 1'b0;
        for (int i = 0; i < STAGES + 2; i++) begin
            step(1'b0, {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0, 1'b0, 1'b1);
        end

        random_phase(300);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
